// File: rtl/spy_pkg.sv
// Shared types and helpers for the spy debug viewer scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spy_pkg;

  // Sequencer states: waiting on a memory read, or displaying the snapshot
  typedef enum logic [0:0] {
    FETCH = 1'b0,
    SHOW  = 1'b1
  } spy_state_e;

  // One LED digit shows one nibble
  localparam int NIB_W = 4;

  // Width of the nibble-select index for a word of data_w bits (at least 1)
  function automatic int nib_sel_w(input int data_w);
    int n;
    n = data_w / NIB_W;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spy_dwell_timer.sv
// Free-running cycle counter with clear/enable; o_tc pulses on the last count.
// Latency: o_tc is combinational on the CYCLES-th enabled cycle after a clear.
// Backpressure: none; i_clr wins over i_en and suppresses o_tc that cycle.
module spy_dwell_timer #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int               CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_last;

  assign w_last = (r_cnt == LAST);
  assign o_tc   = i_en && !i_clr && w_last;

  // Count enabled cycles, restarting from zero on clear or after the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spy_scan_ctrl.sv
// Spy viewer sequencer: fetches a word per address, shows it a nibble at a time (manual or auto dwell).
// Latency: rd_req rises 1 cycle after entering FETCH; output_led follows nib_sel/snapshot by 1 cycle.
// Backpressure: rd_req held until rd_valid or timeout; address/nibble pulses dropped during FETCH.
// Build option: define SPY_SCAN_WRAP_EN for modulo address stepping, otherwise addresses saturate.
module spy_scan_ctrl
  import spy_pkg::*;
#(
  parameter int ADDR_W         = 15,
  parameter int DATA_W         = 128,
  parameter int DWELL_CYCLES   = 100000000,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         addr_up,
  input  logic                         addr_dn,
  input  logic                         nib_up,
  input  logic                         nib_dn,
  input  logic                         auto_tgl,
  output logic                         rd_req,
  output logic [ADDR_W-1:0]            mem_address,
  input  logic                         rd_valid,
  input  logic [DATA_W-1:0]            rd_data,
  output logic [nib_sel_w(DATA_W)-1:0] nib_sel,
  output logic [NIB_W-1:0]             output_led,
  output logic                         auto_on,
  output logic                         rd_err
);

  localparam int                NSEL_W   = nib_sel_w(DATA_W);
  localparam int                NIBS     = DATA_W / NIB_W;
  localparam logic [NSEL_W-1:0] NIB_LAST = NSEL_W'(NIBS - 1);

  spy_state_e         r_state;
  logic [ADDR_W-1:0]  r_addr;
  logic [NSEL_W-1:0]  r_nib;
  logic [DATA_W-1:0]  r_snap;
  logic [NIB_W-1:0]   r_led;
  logic               r_rd_req;
  logic               r_auto_on;
  logic               r_rd_err;

  logic               w_in_show;
  logic               w_fetch_busy;
  logic               w_addr_step;
  logic               w_nib_step;
  logic               w_any_manual;
  logic               w_dwell_clr;
  logic               w_dwell_en;
  logic               w_dwell_tc;
  logic               w_to_clr;
  logic               w_to_en;
  logic               w_to_tc;
  logic [ADDR_W-1:0]  w_addr_inc;
  logic [ADDR_W-1:0]  w_addr_dec;
  logic               w_auto_stop;
  logic [NSEL_W-1:0]  w_nib_inc;
  logic [NSEL_W-1:0]  w_nib_dec;

  assign w_in_show    = (r_state == SHOW);
  assign w_fetch_busy = (r_state == FETCH) && r_rd_req;

  // Opposing pulses in the same cycle cancel each other
  assign w_addr_step  = addr_up ^ addr_dn;
  assign w_nib_step   = nib_up ^ nib_dn;
  assign w_any_manual = addr_up | addr_dn | nib_up | nib_dn;

  // Dwell only runs while showing in auto mode; any manual activity or a toggle
  // restarts it, which also guarantees a manual pulse beats an auto advance
  assign w_dwell_en  = r_auto_on && w_in_show;
  assign w_dwell_clr = !w_in_show || w_any_manual || auto_tgl;

  // Timeout counts only while the request is actually outstanding
  assign w_to_en  = w_fetch_busy;
  assign w_to_clr = !w_fetch_busy || rd_valid;

  spy_dwell_timer #(
    .CYCLES (DWELL_CYCLES)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_dwell_clr),
    .i_en  (w_dwell_en),
    .o_tc  (w_dwell_tc)
  );

  spy_dwell_timer #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_to_clr),
    .i_en  (w_to_en),
    .o_tc  (w_to_tc)
  );

  // Nibble index steps wrap over the number of nibbles in a word
  assign w_nib_inc = (r_nib == NIB_LAST) ? '0 : r_nib + NSEL_W'(1);
  assign w_nib_dec = (r_nib == '0) ? NIB_LAST : r_nib - NSEL_W'(1);

`ifdef SPY_SCAN_WRAP_EN
  // Address arithmetic wraps naturally at the register width
  assign w_addr_inc  = r_addr + ADDR_W'(1);
  assign w_addr_dec  = r_addr - ADDR_W'(1);
  assign w_auto_stop = 1'b0;
`else
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  // Address saturates at both ends; auto scan stops once it reaches the top
  assign w_addr_inc  = (r_addr == ADDR_MAX) ? r_addr : r_addr + ADDR_W'(1);
  assign w_addr_dec  = (r_addr == '0) ? r_addr : r_addr - ADDR_W'(1);
  assign w_auto_stop = (r_addr == ADDR_MAX);
`endif

  // Sequencer: fetch handshake, address/nibble stepping and auto-mode control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FETCH;
      r_addr    <= '0;
      r_nib     <= '0;
      r_snap    <= '0;
      r_rd_req  <= 1'b0;
      r_auto_on <= 1'b0;
      r_rd_err  <= 1'b0;
    end else begin
      if (auto_tgl) begin
        r_auto_on <= !r_auto_on;
      end
      case (r_state)
        FETCH: begin
          if (!r_rd_req) begin
            r_rd_req <= 1'b1;
          end else if (rd_valid) begin
            r_snap   <= rd_data;
            r_rd_req <= 1'b0;
            r_state  <= SHOW;
          end else if (w_to_tc) begin
            r_rd_err <= 1'b1;
            r_rd_req <= 1'b0;
            r_state  <= SHOW;
          end
        end
        SHOW: begin
          if (w_addr_step) begin
            r_addr  <= addr_up ? w_addr_inc : w_addr_dec;
            r_nib   <= '0;
            r_state <= FETCH;
          end else if (w_nib_step) begin
            r_nib <= nib_up ? w_nib_inc : w_nib_dec;
          end else if (w_dwell_tc) begin
            r_nib <= w_nib_inc;
            if (r_nib == NIB_LAST) begin
              r_addr  <= w_addr_inc;
              r_state <= FETCH;
              if (w_auto_stop) begin
                r_auto_on <= 1'b0;
              end
            end
          end
        end
        default: begin
          r_state <= FETCH;
        end
      endcase
    end
  end

  // LED digit register tracks the selected nibble of the snapshot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_led <= '0;
    end else begin
      r_led <= r_snap[r_nib*NIB_W +: NIB_W];
    end
  end

  assign rd_req      = r_rd_req;
  assign mem_address = r_addr;
  assign nib_sel     = r_nib;
  assign output_led  = r_led;
  assign auto_on     = r_auto_on;
  assign rd_err      = r_rd_err;

endmodule

// File: tb/tb_spy_scan_ctrl.sv
// Directed bench for spy_scan_ctrl with short dwell/timeout settings.
// Latency: checks sample 1 time unit after the rising edge.
// Backpressure: rd_valid driven directly by the stimulus sequence.
module tb_spy_scan_ctrl;

  localparam int ADDR_W = 15;
  localparam int DATA_W = 128;

  localparam logic [4:0] P_AU = 5'b10000;
  localparam logic [4:0] P_AD = 5'b01000;
  localparam logic [4:0] P_NU = 5'b00100;
  localparam logic [4:0] P_ND = 5'b00010;
  localparam logic [4:0] P_AT = 5'b00001;

  localparam logic [127:0] D1 = 128'hF000_0000_0000_0000_0000_0000_0000_00A5;
  localparam logic [127:0] D2 = 128'h0000_0000_0000_0000_0000_0000_0000_003C;
  localparam logic [127:0] D3 = 128'hFEDC_BA98_7654_3210_FEDC_BA98_7654_3210;

`ifdef SPY_SCAN_WRAP_EN
  localparam logic [ADDR_W-1:0] ADDR_BELOW_0 = 15'h7FFF;
`else
  localparam logic [ADDR_W-1:0] ADDR_BELOW_0 = 15'h0000;
`endif

  logic              clk;
  logic              rst_n;
  logic              addr_up, addr_dn, nib_up, nib_dn, auto_tgl;
  logic              rd_req;
  logic [ADDR_W-1:0] mem_address;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [4:0]        nib_sel;
  logic [3:0]        output_led;
  logic              auto_on;
  logic              rd_err;

  int n_checks = 0;
  int n_fail   = 0;

  spy_scan_ctrl #(
    .ADDR_W         (ADDR_W),
    .DATA_W         (DATA_W),
    .DWELL_CYCLES   (4),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .addr_up     (addr_up),
    .addr_dn     (addr_dn),
    .nib_up      (nib_up),
    .nib_dn      (nib_dn),
    .auto_tgl    (auto_tgl),
    .rd_req      (rd_req),
    .mem_address (mem_address),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .nib_sel     (nib_sel),
    .output_led  (output_led),
    .auto_on     (auto_on),
    .rd_err      (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle pulse on any combination of {addr_up, addr_dn, nib_up, nib_dn, auto_tgl}
  task automatic pulse(input logic [4:0] p);
    {addr_up, addr_dn, nib_up, nib_dn, auto_tgl} = p;
    tick();
    {addr_up, addr_dn, nib_up, nib_dn, auto_tgl} = 5'b0;
  endtask

  // Wait (bounded) for the request, then answer it immediately
  task automatic serve(input string tag, input logic [127:0] d);
    int n;
    n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req"}, rd_req, 1);
    rd_valid = 1'b1;
    rd_data  = d;
    tick();
    rd_valid = 1'b0;
    check({tag, "_req_drop"}, rd_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    {addr_up, addr_dn, nib_up, nib_dn, auto_tgl} = 5'b0;
    rd_valid = 1'b0;
    rd_data  = '0;
    repeat (3) tick();

    // Reset values
    check("rst_rd_req", rd_req, 0);
    check("rst_addr", mem_address, 0);
    check("rst_nib", nib_sel, 0);
    check("rst_led", output_led, 0);
    check("rst_auto", auto_on, 0);
    check("rst_err", rd_err, 0);

    // Test 1: first fetch, data returned 3 cycles into the request
    rst_n = 1'b1;
    tick();
    check("t1_req_rise", rd_req, 1);
    check("t1_addr", mem_address, 0);
    tick();
    tick();
    rd_valid = 1'b1;
    rd_data  = D1;
    tick();
    rd_valid = 1'b0;
    check("t1_req_drop", rd_req, 0);
    tick();
    check("t1_led_nib0", output_led, 4'h5);
    pulse(P_NU);
    check("t1_nib_up", nib_sel, 1);
    tick();
    check("t1_led_nib1", output_led, 4'hA);
    pulse(P_NU | P_ND);
    check("t1_nib_both", nib_sel, 1);
    pulse(P_ND);
    pulse(P_ND);
    check("t1_nib_wrap_dn", nib_sel, 31);
    tick();
    check("t1_led_nib31", output_led, 4'hF);
    pulse(P_NU);
    check("t1_nib_wrap_up", nib_sel, 0);
    tick();
    check("t1_led_back", output_led, 4'h5);

    // Test 2: unanswered fetch times out after 8 request cycles
    pulse(P_AU);
    check("t2_addr", mem_address, 1);
    check("t2_req_lo", rd_req, 0);
    tick();
    check("t2_req_rise", rd_req, 1);
    n = 0;
    while (rd_req && n < 50) begin
      tick();
      n++;
    end
    check("t2_timeout_cycles", n, 8);
    check("t2_err", rd_err, 1);
    check("t2_led_kept", output_led, 4'h5);
    check("t2_addr_kept", mem_address, 1);

    // Test 5: cancelling address pulses, and an address pulse during FETCH
    pulse(P_AU | P_AD);
    tick();
    check("t5_both_addr", mem_address, 1);
    check("t5_both_noreq", rd_req, 0);
    pulse(P_AU);
    check("t5_addr2", mem_address, 2);
    tick();
    check("t5_req", rd_req, 1);
    pulse(P_AU);
    check("t5_fetch_drop_addr", mem_address, 2);
    check("t5_fetch_req_hold", rd_req, 1);
    rd_valid = 1'b1;
    rd_data  = D2;
    tick();
    rd_valid = 1'b0;
    tick();
    check("t5_led", output_led, 4'hC);
    check("t5_err_sticky", rd_err, 1);

    // Address pulse beats a simultaneous nibble pulse
    pulse(P_NU);
    check("t5_nib1", nib_sel, 1);
    pulse(P_AU | P_NU);
    check("t5_combo_nib", nib_sel, 0);
    check("t5_combo_addr", mem_address, 3);
    tick();
    check("t6_req_before_rst", rd_req, 1);

    // Test 6: asynchronous reset in the middle of a fetch
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rd_req", rd_req, 0);
    check("t6_addr", mem_address, 0);
    check("t6_nib", nib_sel, 0);
    check("t6_led", output_led, 0);
    check("t6_err", rd_err, 0);
    check("t6_auto", auto_on, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_req_after", rd_req, 1);
    check("t6_addr_after", mem_address, 0);
    serve("t6", D3);

    // Test 3: auto mode, dwell of 4 cycles per nibble, rolls to next address
    pulse(P_AT);
    check("t3_auto_on", auto_on, 1);
    check("t3_nib_start", nib_sel, 0);
    for (int a = 1; a <= 32; a++) begin
      repeat (4) tick();
      check("t3_nib", nib_sel, a % 32);
      check("t3_led", output_led, (a - 1) % 16);
    end
    check("t3_addr_next", mem_address, 1);
    tick();
    check("t3_req", rd_req, 1);
    check("t3_auto_kept", auto_on, 1);
    serve("t3", D1);
    pulse(P_AT);
    check("t3_auto_off", auto_on, 0);
    check("t3_nib_hold", nib_sel, 0);

    // Test 4: stepping below address 0
    pulse(P_AD);
    check("t4_addr0", mem_address, 0);
    serve("t4a", D1);
    pulse(P_AD);
    check("t4_below0", mem_address, ADDR_BELOW_0);
    check("t4_req_lo", rd_req, 0);
    tick();
    check("t4_refetch", rd_req, 1);
    serve("t4b", D2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spy_scan_ctrl.md
Name: spy_scan_ctrl

Overview:
Sequencer for the spy debug viewer. It owns the memory address and the nibble select that drive the 4-LED probe display. It fetches one DATA_W-bit word per address through a req/valid handshake, snapshots it, and shows it one nibble at a time. Stepping is either manual, from debounced single-cycle button pulses, or automatic on a dwell timer.

Parameters:
ADDR_W, 15, memory address width
DATA_W, 128, fetched word width; must be a multiple of 4
DWELL_CYCLES, 100000000, clk cycles each nibble is shown in auto mode (>=1)
TIMEOUT_CYCLES, 1024, max cycles to wait for rd_valid (>=1)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
addr_up  in  1  single-cycle pulse: address +1
addr_dn  in  1  single-cycle pulse: address -1
nib_up  in  1  single-cycle pulse: nibble select +1
nib_dn  in  1  single-cycle pulse: nibble select -1
auto_tgl  in  1  single-cycle pulse: toggle auto mode
rd_req  out  1  read request; held high until accepted
mem_address  out  ADDR_W  address of the current/requested word
rd_valid  in  1  read data valid; accepts the request
rd_data  in  DATA_W  read data, sampled when rd_valid=1
nib_sel  out  clog2(DATA_W/4)  displayed nibble index
output_led  out  4  snapshot[4*nib_sel +: 4], registered
auto_on  out  1  auto mode active
rd_err  out  1  sticky: a read timed out

Behaviour:
- Reset (async assert, sync release): state=FETCH, mem_address=0, nib_sel=0, snapshot=0, output_led=0, rd_req=0, auto_on=0, rd_err=0, counters=0.
- States:
  - FETCH: rd_req=1.
    - rd_valid=1 -> snapshot<=rd_data, rd_req<=0, timer cleared, go to SHOW.
    - TIMEOUT_CYCLES elapse without rd_valid -> rd_err<=1, snapshot kept, rd_req<=0, go to SHOW.
    - rd_req rises the first cycle after reset release.
  - SHOW: display state.
    - addr_up/addr_dn -> update mem_address, nib_sel<=0, go to FETCH next cycle.
    - nib_up/nib_dn -> nib_sel ±1, wrapping modulo DATA_W/4 in both directions.
    - Auto mode: dwell counter counts to DWELL_CYCLES-1, then nib_sel+1 and counter cleared. When nib_sel wraps from DATA_W/4-1 to 0, mem_address+1 and go to FETCH.
    - Any manual pulse clears the dwell counter.
- Simultaneous pulses:
  - addr_up and addr_dn together: both ignored.
  - nib_up and nib_dn together: both ignored.
  - An address pulse together with a nibble pulse: the address pulse wins.
  - An auto advance together with a manual pulse: the manual pulse wins.
- Pulses in FETCH: addr/nib pulses are dropped. auto_tgl is honoured in any state.
- auto_tgl: auto_on flips the next cycle. Leaving auto mode clears the dwell counter.
- output_led: registered, updates 1 cycle after a nib_sel or snapshot change.
- mem_address and rd_req are stable for the whole FETCH state.
- rd_err clears only on reset.
- rd_valid seen outside FETCH is ignored.
- Address boundary: see optional feature.

Optional Feature:
SPY_SCAN_WRAP_EN
- Defined: mem_address wraps modulo 2^ADDR_W (max+1 -> 0, 0-1 -> max). This applies to manual steps and auto advance.
- Undefined: mem_address saturates at 0 and 2^ADDR_W-1.
  - A saturated manual step still refetches the same address.
  - In auto mode, reaching max with nib_sel wrapping clears auto_on and goes to FETCH of the same address.

Decomposition:
- Package spy_pkg holds:
  - the state enum (FETCH, SHOW);
  - constant NIB_W=4;
  - the function computing the nib_sel width, clog2(DATA_W/4).
- One sub-module, spy_dwell_timer: a cycle counter with clear, enable, and terminal-count pulse. It is instantiated twice: once for the dwell counter and once for the fetch timeout.

Test Plan:
1. Reset release, rd_valid 3 cycles after rd_req, rd_data=128'h...0000_00A5 -> mem_address=0, output_led=4'h5; after nib_up, output_led=4'hA.
2. Hold rd_valid=0 with TIMEOUT_CYCLES=8 -> rd_req drops after exactly 8 cycles in FETCH, rd_err=1, snapshot unchanged.
3. Auto mode with DWELL_CYCLES=4 -> nib_sel advances every 4 cycles; after 32 advances, mem_address=1 and rd_req=1.
4. addr_dn at address 0 -> with SPY_SCAN_WRAP_EN mem_address=0x7FFF; without it mem_address=0 and a refetch is issued.
5. addr_up and addr_dn in the same cycle -> no change. addr_up during FETCH -> dropped, mem_address unchanged.
6. rst_n asserted mid-FETCH -> all outputs return to reset values asynchronously; after release, a fetch of address 0 is issued.
